alu_wb_seq: RTL
===============

ALU_WB_SEQ -- requirements
Module: alu_wb_seq

Interface
REQ-001 No parameters; all datapaths SHALL be fixed at 4 bits, register addresses at 3 bits.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 CLRN  in  1  asynchronous, active-low reset.
REQ-004 START  in  1  request to execute the instruction on OP/RD/RS/RT/IMM.
REQ-005 OP  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LDI, 110 MOV, 111 NOP.
REQ-006 RD, RS, RT  in  3 each  destination, source-P and source-Q register addresses.
REQ-007 IMM  in  4  immediate operand for LDI.
REQ-008 DATAP, DATAQ  in  4 each  register-file read data for the RP/RQ ports; combinational w.r.t. RP/RQ.
REQ-009 RP, RQ  out  3 each  register-file read addresses.
REQ-010 WA  out  3  register-file write address; LD_DATA  out  4  write data; WR  out  1  write enable.
REQ-011 BUSY  out  1  high from acceptance of START until return to IDLE; DONE  out  1  one-cycle completion pulse.
REQ-012 CARRY, ZERO  out  1 each  status flags (see Configuration).

Function
REQ-013 FSM states SHALL be IDLE, READ, EXEC, WRITE; encoding free.
REQ-014 IDLE: on START=1, latch OP, RD, RS, RT, IMM and go to READ; otherwise stay.
REQ-015 READ: drive RP=latched RS, RQ=latched RT; capture DATAP->A, DATAQ->B at end of cycle; go to EXEC.
REQ-016 EXEC: compute 4-bit RES from A, B, IMM; update flags; go to WRITE.
REQ-017 ADD: RES=(A+B) mod 16; SUB: RES=(A-B) mod 16; AND/OR/XOR bitwise; LDI: RES=IMM; MOV: RES=A.
REQ-018 WRITE: WA=latched RD, LD_DATA=RES, WR=1 for exactly this cycle, except NOP where WR=0; go to IDLE.
REQ-019 DONE SHALL be 1 for exactly the first IDLE cycle following WRITE, 0 otherwise.
REQ-020 Latency: START sampled at edge n -> WR high during cycle n+3 -> DONE high during cycle n+4.
REQ-021 START while BUSY=1 SHALL be ignored (no queuing); START asserted in the DONE cycle SHALL be accepted.
REQ-022 RP, RQ, WA, LD_DATA SHALL hold their last values outside READ/WRITE; WR, DONE, BUSY SHALL be registered outputs (glitch-free).
REQ-023 RD equal to RS or RT SHALL be legal; operands are captured in READ before the write.
REQ-024 Instruction inputs changing after acceptance SHALL NOT affect the executing instruction.

Reset
REQ-025 CLRN=0 SHALL immediately force state IDLE and WR=0, DONE=0, BUSY=0, RP=RQ=WA=0, LD_DATA=0, CARRY=0, ZERO=0, A=B=RES=0.
REQ-026 Reset mid-instruction SHALL abort it with no write; first START after CLRN rises SHALL be accepted normally.

Configuration
REQ-027 Macro ALU_WB_SEQ_FLAGS_EN: when defined, flags update in EXEC for every op except NOP; ZERO=(RES==0); CARRY=carry-out for ADD, borrow (A<B unsigned) for SUB, 0 for other ops; flags hold until next non-NOP EXEC.
REQ-028 When ALU_WB_SEQ_FLAGS_EN is undefined, CARRY and ZERO SHALL be constant 0 and no flag storage SHALL exist.

Verification
REQ-029 Reset, LDI RD=3 IMM=1010 START 1 cycle -> WR=1 in cycle n+3 with WA=3, LD_DATA=1010; DONE in n+4.
REQ-030 R1=0111, R2=1011, ADD RD=4 RS=1 RT=2 -> LD_DATA=0010, WA=4; with FLAGS_EN CARRY=1, ZERO=0.
REQ-031 R1=0011, R2=0101, SUB RD=1 RS=1 RT=1 -> LD_DATA=0000; with FLAGS_EN ZERO=1, CARRY=0; then SUB RS=1 RT=2 (R1=0) -> LD_DATA=1011, CARRY=1.
REQ-032 START held high continuously for 10 cycles -> instructions accepted only in IDLE/DONE cycles, exactly two WR pulses, BUSY low only in DONE cycles.
REQ-033 NOP -> no WR pulse, DONE at n+4, flags unchanged.
REQ-034 CLRN low during EXEC of ADD -> WR never asserted, all outputs 0 at once; next LDI completes with standard latency.

Source files
------------

// File: rtl/alu_wb_seq.sv
// alu_wb_seq: four-state sequencer (IDLE/READ/EXEC/WRITE) around a 4-bit ALU and an external register file.
// Latency: START sampled at edge n -> WR high in cycle n+3 -> DONE pulse in cycle n+4.
// No backpressure: START is only accepted in IDLE (including the DONE cycle); START while BUSY is dropped.
// Optional feature: define ALU_WB_SEQ_FLAGS_EN to get CARRY/ZERO status flags; otherwise both are tied to 0.
module alu_wb_seq (
    input  logic       i_clk,
    input  logic       i_clrn,
    input  logic       i_start,
    input  logic [2:0] i_op,
    input  logic [2:0] i_rd,
    input  logic [2:0] i_rs,
    input  logic [2:0] i_rt,
    input  logic [3:0] i_imm,
    input  logic [3:0] i_datap,
    input  logic [3:0] i_dataq,
    output logic [2:0] o_rp,
    output logic [2:0] o_rq,
    output logic [2:0] o_wa,
    output logic [3:0] o_ld_data,
    output logic       o_wr,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_carry,
    output logic       o_zero
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;

    // Instruction fields latched at acceptance; source addresses live directly in r_rp/r_rq.
    logic [2:0] r_op;
    logic [2:0] r_rd;
    logic [3:0] r_imm;

    // Operand and result registers.
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_res;

    // Output registers.
    logic [2:0] r_rp;
    logic [2:0] r_rq;
    logic [2:0] r_wa;
    logic [3:0] r_ld_data;
    logic       r_wr;
    logic       r_done;
    logic       r_busy;

    logic [3:0] w_res;
    logic       w_accept;

    assign w_accept = (r_state == S_IDLE) && i_start;

    // State register.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one cycle per phase, START only considered in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_start ? S_READ : S_IDLE;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ALU: NOP keeps the previous result so LD_DATA stays stable.
    always_comb begin
        w_res = r_res;
        case (r_op)
            OP_ADD:  w_res = r_a + r_b;
            OP_SUB:  w_res = r_a - r_b;
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_XOR:  w_res = r_a ^ r_b;
            OP_LDI:  w_res = r_imm;
            OP_MOV:  w_res = r_a;
            OP_NOP:  w_res = r_res;
            default: w_res = r_res;
        endcase
    end

    // Latch the instruction on acceptance so later input changes cannot disturb it.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_op  <= OP_NOP;
            r_rd  <= 3'd0;
            r_imm <= 4'd0;
            r_rp  <= 3'd0;
            r_rq  <= 3'd0;
        end else if (w_accept) begin
            r_op  <= i_op;
            r_rd  <= i_rd;
            r_imm <= i_imm;
            r_rp  <= i_rs;
            r_rq  <= i_rt;
        end
    end

    // Capture read data at the end of READ; operands are therefore taken before any write-back.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_a <= 4'd0;
            r_b <= 4'd0;
        end else if (r_state == S_READ) begin
            r_a <= i_datap;
            r_b <= i_dataq;
        end
    end

    // Result and write-port address/data are loaded at the end of EXEC so they are valid for WRITE.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_res     <= 4'd0;
            r_wa      <= 3'd0;
            r_ld_data <= 4'd0;
        end else if (r_state == S_EXEC) begin
            r_res     <= w_res;
            r_wa      <= r_rd;
            r_ld_data <= w_res;
        end
    end

    // Registered control outputs, computed from the upcoming state so they are glitch-free.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_wr   <= (r_state == S_EXEC) && (r_op != OP_NOP);
            r_done <= (r_state == S_WRITE);
            r_busy <= (w_next != S_IDLE);
        end
    end

`ifdef ALU_WB_SEQ_FLAGS_EN
    logic r_carry;
    logic r_zero;
    logic w_carry;

    // Carry-out for ADD, borrow for SUB, cleared for the logical/move ops.
    always_comb begin
        w_carry = 1'b0;
        case (r_op)
            OP_ADD:  w_carry = (({1'b0, r_a} + {1'b0, r_b}) > 5'd15);
            OP_SUB:  w_carry = (r_a < r_b);
            default: w_carry = 1'b0;
        endcase
    end

    // Flags follow every executed op except NOP, then hold.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if ((r_state == S_EXEC) && (r_op != OP_NOP)) begin
            r_carry <= w_carry;
            r_zero  <= (w_res == 4'd0);
        end
    end

    assign o_carry = r_carry;
    assign o_zero  = r_zero;
`else
    assign o_carry = 1'b0;
    assign o_zero  = 1'b0;
`endif

    assign o_rp      = r_rp;
    assign o_rq      = r_rq;
    assign o_wa      = r_wa;
    assign o_ld_data = r_ld_data;
    assign o_wr      = r_wr;
    assign o_done    = r_done;
    assign o_busy    = r_busy;

endmodule
